eq_kernel_sequencer: RTL and testbench

- Sequences the EQ HLS kernel through frames using its ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_idle).
- Snoops the kernel's in_stream and out_stream AXI-Stream handshakes to count beats per frame and detect stalls.
- Opens a one-cycle coefficient-update window between frames.
- Sits between the PS-side control registers and the EQ kernel; purely observational on the stream data paths.

---
 rtl/eq_seq_pkg.sv | 24 ++
 rtl/eq_stall_watchdog.sv | 63 ++++++
 rtl/eq_kernel_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_eq_kernel_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_seq_pkg.sv
// eq_seq_pkg
//   Shared types and constants for the EQ kernel sequencer.
//   - seq_state_e : sequencer FSM states
//   - STALL_IN / STALL_OUT : bit positions inside stall_src
//   - DEF_* : default parameter values for the sequencer and its watchdog
package eq_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      STALL = 3'd3,
      GAP   = 3'd4,
      DONE  = 3'd5
   } seq_state_e;

   localparam int STALL_IN  = 0;
   localparam int STALL_OUT = 1;

   localparam int DEF_FRAME_LEN   = 256;
   localparam int DEF_WDOG_CYCLES = 4096;
   localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/eq_stall_watchdog.sv
// eq_stall_watchdog
//   Detects stream beats on the snooped kernel streams and times out when
//   neither stream moves for WDOG_CYCLES consecutive armed cycles.
// Ports:
//   ap_clk, ap_rst_n            clock, asynchronous active-low reset
//   in_tvalid_i, in_tready_i    snoop of kernel input stream
//   out_tvalid_i, out_tready_i  snoop of kernel output stream
//   arm_i                       count only while armed; counter held at 0 otherwise
//   clear_i                     restart the timeout count
//   beat_o                      a beat on either stream this cycle
//   expire_o                    timeout reached this cycle (armed, no beat)
//   src_o                       stall cause seen this cycle, bit STALL_IN / STALL_OUT
module eq_stall_watchdog
   import eq_seq_pkg::*;
#(
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic       ap_clk,
   input  logic       ap_rst_n,
   input  logic       in_tvalid_i,
   input  logic       in_tready_i,
   input  logic       out_tvalid_i,
   input  logic       out_tready_i,
   input  logic       arm_i,
   input  logic       clear_i,
   output logic       beat_o,
   output logic       expire_o,
   output logic [1:0] src_o
);

   localparam int              WD_W    = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

   always_comb begin
      beat_o = (in_tvalid_i & in_tready_i) | (out_tvalid_i & out_tready_i);

      // The counter holds the number of idle cycles already seen, so the
      // cycle that finds it at WD_LAST is the WDOG_CYCLES-th idle cycle.
      expire_o = arm_i & ~beat_o & (wd_cnt_q == WD_LAST);

      src_o            = '0;
      src_o[STALL_IN]  = in_tready_i & ~in_tvalid_i;
      src_o[STALL_OUT] = out_tvalid_i & ~out_tready_i;

      wd_cnt_d = wd_cnt_q;
      if (!arm_i || clear_i || beat_o) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_LAST) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

endmodule

// File: rtl/eq_kernel_sequencer.sv
// eq_kernel_sequencer
//   Drives the EQ HLS kernel frame by frame over its ap_ctrl_hs handshake,
//   snoops both AXI-Stream interfaces for beat counting and stall detection,
//   and opens a one-cycle coefficient-update window between frames.
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   cfg_enable                run request (level)
//   cfg_frames                frames to run, 0 = continuous (sampled when leaving IDLE)
//   sw_clear                  clears sticky status (a same-cycle set wins)
//   k_ap_start                registered kernel start, high only in START
//   k_ap_ready/done/idle      kernel handshake status
//   in_*/out_* tvalid/tready  stream snoops (observed only)
//   busy                      sequencer not IDLE
//   frame_cnt                 frames completed since the last start from IDLE
//   coef_win                  one-cycle coefficient window (GAP)
//   done_pulse                one-cycle pulse when the programmed count is reached
//   stall_flag, stall_src     sticky watchdog status and cause
//   len_err                   sticky frame length mismatch
module eq_kernel_sequencer
   import eq_seq_pkg::*;
#(
   parameter int FRAME_LEN   = DEF_FRAME_LEN,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             cfg_enable,
   input  logic [CNT_W-1:0] cfg_frames,
   input  logic             sw_clear,
   output logic             k_ap_start,
   input  logic             k_ap_ready,
   input  logic             k_ap_done,
   input  logic             k_ap_idle,
   input  logic             in_tvalid,
   input  logic             in_tready,
   input  logic             out_tvalid,
   input  logic             out_tready,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             coef_win,
   output logic             done_pulse,
   output logic             stall_flag,
   output logic [1:0]       stall_src,
   output logic             len_err
);

   localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
      return (en && (c != '1)) ? c + 1'b1 : c;
   endfunction

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] frames_q, frames_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             stall_flag_q, stall_flag_d;
   logic [1:0]       stall_src_q, stall_src_d;
   logic             len_err_q, len_err_d;
   logic             k_ap_start_q, k_ap_start_d;
   logic             coef_win_q, coef_win_d;
   logic             done_pulse_q, done_pulse_d;

   logic             in_beat, out_beat;
   logic             wd_arm, wd_clear, wd_expire, any_beat;
   logic [1:0]       wd_src;
   logic             len_chk;

   assign in_beat  = in_tvalid & in_tready;
   assign out_beat = out_tvalid & out_tready;
   assign wd_arm   = (state_q == RUN);

   eq_stall_watchdog #(
      .WDOG_CYCLES (WDOG_CYCLES)
   ) u_wdog (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .in_tvalid_i  (in_tvalid),
      .in_tready_i  (in_tready),
      .out_tvalid_i (out_tvalid),
      .out_tready_i (out_tready),
      .arm_i        (wd_arm),
      .clear_i      (wd_clear),
      .beat_o       (any_beat),
      .expire_o     (wd_expire),
      .src_o        (wd_src)
   );

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt_q;
      frames_d     = frames_q;
      in_cnt_d     = sat_inc(in_cnt_q, in_beat);
      out_cnt_d    = sat_inc(out_cnt_q, out_beat);
      stall_flag_d = stall_flag_q & ~sw_clear;
      stall_src_d  = stall_src_q & {2{~sw_clear}};
      len_err_d    = len_err_q & ~sw_clear;
      wd_clear     = 1'b0;
      len_chk      = 1'b0;

      case (state_q)
         IDLE: begin
            if (cfg_enable && k_ap_idle) begin
               state_d     = START;
               frame_cnt_d = '0;
               frames_d    = cfg_frames;
            end
         end
         START: begin
            if (k_ap_ready) begin
               in_cnt_d  = '0;
               out_cnt_d = '0;
               wd_clear  = 1'b1;
               state_d   = k_ap_done ? GAP : RUN;
            end
         end
         RUN: begin
            // Completion takes priority over a timeout in the same cycle.
            if (k_ap_done) begin
               state_d = GAP;
               len_chk = 1'b1;
            end else if (wd_expire) begin
               state_d      = STALL;
               stall_flag_d = 1'b1;
               stall_src_d  = stall_src_d | wd_src;
            end
         end
         STALL: begin
            if (k_ap_done) begin
               state_d = GAP;
               len_chk = 1'b1;
            end else if (any_beat) begin
               state_d = RUN;
            end
         end
         GAP: begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if ((frames_q != '0) && (CNT_W'(frame_cnt_q + 1'b1) == frames_q)) begin
               state_d = DONE;
            end else if (!cfg_enable) begin
               state_d = IDLE;
            end else begin
               state_d = START;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The _d counts already include a beat landing in the done cycle.
      if (len_chk && ((in_cnt_d != FRAME_LEN_C) || (out_cnt_d != FRAME_LEN_C))) begin
         len_err_d = 1'b1;
      end

      k_ap_start_d = (state_d == START);
      coef_win_d   = (state_d == GAP);
      done_pulse_d = (state_d == DONE);
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q      <= IDLE;
         frame_cnt_q  <= '0;
         frames_q     <= '0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         stall_flag_q <= 1'b0;
         stall_src_q  <= '0;
         len_err_q    <= 1'b0;
         k_ap_start_q <= 1'b0;
         coef_win_q   <= 1'b0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         frames_q     <= frames_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         stall_flag_q <= stall_flag_d;
         stall_src_q  <= stall_src_d;
         len_err_q    <= len_err_d;
         k_ap_start_q <= k_ap_start_d;
         coef_win_q   <= coef_win_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign frame_cnt  = frame_cnt_q;
   assign k_ap_start = k_ap_start_q;
   assign coef_win   = coef_win_q;
   assign done_pulse = done_pulse_q;
   assign stall_flag = stall_flag_q;
   assign stall_src  = stall_src_q;
   assign len_err    = len_err_q;

endmodule

// File: tb/tb_eq_kernel_sequencer.sv
// tb_eq_kernel_sequencer
//   Directed bench with a simple HLS-kernel model. Expected handshake,
//   coefficient-window and done events are queued by the stimulus; a monitor
//   pops and compares them whenever the DUT presents one.
module tb_eq_kernel_sequencer;

   localparam int CNT_W = 16;
   localparam int FL    = 8;
   localparam int WD    = 16;

   localparam int K_HS   = 0;
   localparam int K_COEF = 1;
   localparam int K_DONE = 2;

   logic             ap_clk = 1'b0;
   logic             ap_rst_n = 1'b0;
   logic             cfg_enable = 1'b0;
   logic [CNT_W-1:0] cfg_frames = '0;
   logic             sw_clear = 1'b0;
   logic             k_ap_start;
   logic             k_ap_ready = 1'b0;
   logic             k_ap_done = 1'b0;
   logic             k_ap_idle = 1'b1;
   logic             in_tvalid = 1'b0;
   logic             in_tready = 1'b0;
   logic             out_tvalid = 1'b0;
   logic             out_tready = 1'b0;
   logic             busy;
   logic [CNT_W-1:0] frame_cnt;
   logic             coef_win;
   logic             done_pulse;
   logic             stall_flag;
   logic [1:0]       stall_src;
   logic             len_err;

   always #5 ap_clk = ~ap_clk;

   eq_kernel_sequencer #(
      .FRAME_LEN   (FL),
      .CNT_W       (CNT_W),
      .WDOG_CYCLES (WD)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .cfg_enable (cfg_enable),
      .cfg_frames (cfg_frames),
      .sw_clear   (sw_clear),
      .k_ap_start (k_ap_start),
      .k_ap_ready (k_ap_ready),
      .k_ap_done  (k_ap_done),
      .k_ap_idle  (k_ap_idle),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .coef_win   (coef_win),
      .done_pulse (done_pulse),
      .stall_flag (stall_flag),
      .stall_src  (stall_src),
      .len_err    (len_err)
   );

   typedef struct {
      int kind;
      int fc;
      int len;
      int sflag;
      int src;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push(input int kind, input int fc, input int len, input int sf, input int src);
      exp_t e;
      e.kind = kind; e.fc = fc; e.len = len; e.sflag = sf; e.src = src;
      sbq.push_back(e);
   endtask

   task automatic pop_check(input int kind);
      exp_t e;
      if (sbq.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
      end else begin
         e = sbq.pop_front();
         check("event_kind", kind, e.kind);
         check("ev_frame_cnt", int'(frame_cnt), e.fc);
         check("ev_len_err", int'(len_err), e.len);
         check("ev_stall_flag", int'(stall_flag), e.sflag);
         check("ev_stall_src", int'(stall_src), e.src);
      end
   endtask

   // Monitor: samples on the falling edge, away from register updates.
   always @(negedge ap_clk) begin
      if (ap_rst_n) begin
         if (k_ap_start && k_ap_ready) pop_check(K_HS);
         if (coef_win)                 pop_check(K_COEF);
         if (done_pulse)               pop_check(K_DONE);
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Kernel model: wait for start, hold ready off for dly cycles, accept.
   task automatic kstart(input int dly);
      int w;
      w = 0;
      while (!k_ap_start && w < 20) begin
         tick();
         w++;
      end
      if (!k_ap_start) begin
         check("start_timeout", int'(k_ap_start), 1);
      end else begin
         for (int i = 0; i < dly; i++) begin
            tick();
            check("start_held", int'(k_ap_start), 1);
         end
         k_ap_ready = 1'b1;
         k_ap_idle  = 1'b0;
         tick();
         k_ap_ready = 1'b0;
         check("start_dropped", int'(k_ap_start), 0);
      end
   endtask

   // Kernel model body: optional input starvation, nin input beats,
   // nout output beats, then a one-cycle done.
   task automatic kbody(input int nin, input int nout, input int starve);
      if (starve > 0) begin
         in_tready = 1'b1;
         for (int i = 0; i < starve; i++) begin
            tick();
            if (i == starve - 2) check("no_early_stall", int'(stall_flag), 0);
         end
         check("stall_flag_set", int'(stall_flag), 1);
         in_tready = 1'b0;
      end
      in_tvalid = 1'b1; in_tready = 1'b1;
      repeat (nin) tick();
      in_tvalid = 1'b0; in_tready = 1'b0;
      out_tvalid = 1'b1; out_tready = 1'b1;
      repeat (nout) tick();
      out_tvalid = 1'b0; out_tready = 1'b0;
      k_ap_done = 1'b1;
      tick();
      k_ap_done = 1'b0;
      k_ap_idle = 1'b1;
   endtask

   task automatic pulse_clear();
      sw_clear = 1'b1;
      tick();
      sw_clear = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_start", int'(k_ap_start), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_cnt", int'(frame_cnt), 0);
      check("rst_coef_win", int'(coef_win), 0);
      check("rst_done_pulse", int'(done_pulse), 0);
      check("rst_flags", int'({stall_flag, stall_src, len_err}), 0);
      ap_rst_n = 1'b1;
      tick();

      // Three frames; second frame's ready is delayed 5 cycles
      cfg_frames = 3;
      cfg_enable = 1'b1;
      for (int f = 0; f < 3; f++) begin
         push(K_HS, f, 0, 0, 0);
         push(K_COEF, f, 0, 0, 0);
      end
      push(K_DONE, 3, 0, 0, 0);
      kstart(0); kbody(FL, FL, 0);
      kstart(5); kbody(FL, FL, 0);
      kstart(0); cfg_enable = 1'b0; kbody(FL, FL, 0);
      repeat (4) tick();
      check("a_busy", int'(busy), 0);
      check("a_frame_cnt", int'(frame_cnt), 3);
      check("a_drained", sbq.size(), 0);

      // Input starvation -> stall, then recovery and normal completion
      cfg_frames = 1;
      cfg_enable = 1'b1;
      push(K_HS, 0, 0, 0, 0);
      push(K_COEF, 0, 0, 1, 1);
      push(K_DONE, 1, 0, 1, 1);
      kstart(0); cfg_enable = 1'b0; kbody(FL, FL, WD);
      repeat (4) tick();
      check("s_stall_src", int'(stall_src), 1);
      pulse_clear();
      check("s_clear_flag", int'(stall_flag), 0);
      check("s_clear_src", int'(stall_src), 0);

      // Short output frame -> len_err, then cleared by software
      cfg_enable = 1'b1;
      push(K_HS, 0, 0, 0, 0);
      push(K_COEF, 0, 1, 0, 0);
      push(K_DONE, 1, 1, 0, 0);
      kstart(0); cfg_enable = 1'b0; kbody(FL, FL - 1, 0);
      repeat (4) tick();
      check("l_len_err", int'(len_err), 1);
      pulse_clear();
      check("l_len_err_clr", int'(len_err), 0);

      // Continuous mode, enable dropped mid-frame: one window, no done
      cfg_frames = 0;
      cfg_enable = 1'b1;
      push(K_HS, 0, 0, 0, 0);
      push(K_COEF, 0, 0, 0, 0);
      kstart(0); cfg_enable = 1'b0; kbody(FL, FL, 0);
      repeat (6) tick();
      check("c_busy", int'(busy), 0);
      check("c_frame_cnt", int'(frame_cnt), 1);
      check("c_start", int'(k_ap_start), 0);
      check("c_drained", sbq.size(), 0);

      // Asynchronous reset mid-run with a sticky stall pending
      cfg_enable = 1'b1;
      push(K_HS, 0, 0, 0, 0);
      kstart(0);
      in_tready = 1'b1;
      repeat (WD) tick();
      check("r_stall_pre", int'(stall_flag), 1);
      in_tvalid = 1'b1;
      repeat (3) tick();
      ap_rst_n = 1'b0;
      #1;
      check("r_start", int'(k_ap_start), 0);
      check("r_busy", int'(busy), 0);
      check("r_stall_flag", int'(stall_flag), 0);
      check("r_stall_src", int'(stall_src), 0);
      check("r_len_err", int'(len_err), 0);
      check("r_frame_cnt", int'(frame_cnt), 0);
      in_tvalid = 1'b0; in_tready = 1'b0;
      k_ap_idle = 1'b1;
      cfg_frames = 1;
      repeat (2) tick();
      ap_rst_n = 1'b1;
      push(K_HS, 0, 0, 0, 0);
      push(K_COEF, 0, 0, 0, 0);
      push(K_DONE, 1, 0, 0, 0);
      tick();
      check("r_restart_start", int'(k_ap_start), 1);
      check("r_restart_fc", int'(frame_cnt), 0);
      kstart(0); cfg_enable = 1'b0; kbody(FL, FL, 0);
      repeat (4) tick();
      check("r_frame_cnt_end", int'(frame_cnt), 1);
      check("r_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
